// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NUM_CH sram-like master ports onto one sram-like slave port.
// Accepted requests are tracked in an in-order ID FIFO, so each response is routed back
// to the channel that issued it.
//
// Optional feature macro: RR_ARB_EN
//   defined   -> round-robin arbitration starting at rr_q
//   undefined -> fixed priority, highest channel index wins
//
// Ports:
//   clk, resetn                 clock (rising edge), asynchronous active-low reset
//   m_req/m_wr/m_size/m_wstrb/m_addr/m_wdata  per-channel request, slice i = channel i
//   m_addr_ok, m_data_ok        per-channel accept / response strobes
//   m_rdata                     read data, broadcast, qualified by m_data_ok
//   s_req/s_wr/s_size/s_wstrb/s_addr/s_wdata  downstream request from the granted channel
//   s_addr_ok, s_data_ok, s_rdata             downstream accept / in-order response
//   outst_cnt                   number of accepted-but-unanswered requests
//   proto_err                   sticky: response seen while nothing was outstanding
module sram_like_arbiter #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_CH-1:0]               m_req,
    input  logic [NUM_CH-1:0]               m_wr,
    input  logic [2*NUM_CH-1:0]             m_size,
    input  logic [DW/8*NUM_CH-1:0]          m_wstrb,
    input  logic [AW*NUM_CH-1:0]            m_addr,
    input  logic [DW*NUM_CH-1:0]            m_wdata,
    output logic [NUM_CH-1:0]               m_addr_ok,
    output logic [NUM_CH-1:0]               m_data_ok,
    output logic [DW-1:0]                   m_rdata,
    output logic                            s_req,
    output logic                            s_wr,
    output logic [1:0]                      s_size,
    output logic [DW/8-1:0]                 s_wstrb,
    output logic [AW-1:0]                   s_addr,
    output logic [DW-1:0]                   s_wdata,
    input  logic                            s_addr_ok,
    input  logic                            s_data_ok,
    input  logic [DW-1:0]                   s_rdata,
    output logic [$clog2(MAX_OUTST+1)-1:0]  outst_cnt,
    output logic                            proto_err
);

    localparam int unsigned IDW = $clog2(NUM_CH);
    localparam int unsigned PW  = $clog2(MAX_OUTST);
    localparam int unsigned CW  = $clog2(MAX_OUTST + 1);
    localparam int unsigned SW  = DW / 8;

    logic [IDW-1:0] id_mem_q [MAX_OUTST];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic           proto_q, proto_d;

    logic [IDW-1:0] arb_win;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] head;
    logic           full, empty, push, pop;

`ifdef RR_ARB_EN
    logic [IDW-1:0] rr_q, rr_d;

    // Lowest requester at or above rr_q, else lowest requester overall (wrap-around).
    always_comb begin
        logic           found_hi;
        logic [IDW-1:0] win_hi, win_lo;
        found_hi = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m_req[i]) begin
                win_lo = IDW'(i);
                if (IDW'(i) >= rr_q) begin
                    win_hi   = IDW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        arb_win = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        rr_d = rr_q;
        if (push) begin
            rr_d = (grant == IDW'(NUM_CH - 1)) ? '0 : grant + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rr_q <= '0;
        else         rr_q <= rr_d;
    end
`else
    // Ascending scan with overwrite leaves the highest requesting index.
    always_comb begin
        arb_win = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_req[i]) arb_win = IDW'(i);
        end
    end
`endif

    // A stalled request keeps its grant so the downstream request stays stable.
    assign grant = lock_q ? lock_id_q : arb_win;
    assign full  = (cnt_q == CW'(MAX_OUTST));
    assign empty = (cnt_q == '0);
    assign s_req = resetn & (|m_req) & ~full;
    assign push  = s_req & s_addr_ok;
    assign pop   = resetn & s_data_ok & ~empty;
    assign head  = id_mem_q[rptr_q];

    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == IDW'(i)) begin
                s_wr    = m_wr[i];
                s_size  = m_size[i*2 +: 2];
                s_wstrb = m_wstrb[i*SW +: SW];
                s_addr  = m_addr[i*AW +: AW];
                s_wdata = m_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_addr_ok[i] = push & (grant == IDW'(i));
            m_data_ok[i] = pop & (head == IDW'(i));
        end
    end

    assign m_rdata   = s_rdata;
    assign outst_cnt = cnt_q;
    assign proto_err = proto_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (push) begin
            lock_d = 1'b0;
        end else if (s_req) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
    end

    assign proto_d = proto_q | (s_data_ok & empty);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            proto_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            proto_q   <= proto_d;
        end
    end

    // ID storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) id_mem_q[wptr_q] <= grant;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

    localparam int NUM_CH    = 2;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_OUTST = 4;
    localparam int SW        = DW / 8;
    localparam int CW        = $clog2(MAX_OUTST + 1);

    logic                   clk;
    logic                   resetn;
    logic [NUM_CH-1:0]      m_req, m_wr;
    logic [2*NUM_CH-1:0]    m_size;
    logic [SW*NUM_CH-1:0]   m_wstrb;
    logic [AW*NUM_CH-1:0]   m_addr;
    logic [DW*NUM_CH-1:0]   m_wdata;
    logic [NUM_CH-1:0]      m_addr_ok, m_data_ok;
    logic [DW-1:0]          m_rdata;
    logic                   s_req, s_wr;
    logic [1:0]             s_size;
    logic [SW-1:0]          s_wstrb;
    logic [AW-1:0]          s_addr;
    logic [DW-1:0]          s_wdata;
    logic                   s_addr_ok, s_data_ok;
    logic [DW-1:0]          s_rdata;
    logic [CW-1:0]          outst_cnt;
    logic                   proto_err;

    int checks = 0;
    int errors = 0;

    sram_like_arbiter #(
        .NUM_CH   (NUM_CH),
        .AW       (AW),
        .DW       (DW),
        .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_size   (m_size),
        .m_wstrb  (m_wstrb),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok),
        .m_rdata  (m_rdata),
        .s_req    (s_req),
        .s_wr     (s_wr),
        .s_size   (s_size),
        .s_wstrb  (s_wstrb),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok),
        .s_rdata  (s_rdata),
        .outst_cnt(outst_cnt),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int q[$];          // channel IDs of accepted, unanswered requests, oldest first
    bit mdl_proto;
    bit pend;          // a request was offered downstream but not yet taken
    int pend_id;
    int rr;

    function automatic int winner(input logic [NUM_CH-1:0] req, input int ptr);
`ifdef RR_ARB_EN
        for (int k = 0; k < NUM_CH; k++) begin
            if (req[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
        end
        return 0;
`else
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) return i;
        end
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        int g;
        bit e_sreq, dopop;
        logic [NUM_CH-1:0] one, e_aok, e_dok;
        one = 1;
        if (!resetn) begin
            q.delete();
            mdl_proto = 0;
            pend      = 0;
            rr        = 0;
            chk("rst_s_req", s_req, 0);
            chk("rst_m_addr_ok", m_addr_ok, 0);
            chk("rst_m_data_ok", m_data_ok, 0);
            chk("rst_outst_cnt", outst_cnt, 0);
            chk("rst_proto_err", proto_err, 0);
        end else begin
            e_sreq = (m_req != 0) && (q.size() < MAX_OUTST);
            g      = pend ? pend_id : winner(m_req, rr);
            e_aok  = (e_sreq && s_addr_ok) ? (one << g) : '0;
            dopop  = s_data_ok && (q.size() > 0);
            e_dok  = dopop ? (one << q[0]) : '0;
            chk("mon_s_req", s_req, e_sreq);
            chk("mon_m_addr_ok", m_addr_ok, e_aok);
            chk("mon_m_data_ok", m_data_ok, e_dok);
            chk("mon_outst_cnt", outst_cnt, q.size());
            chk("mon_proto_err", proto_err, mdl_proto);
            if (e_sreq) begin
                chk("mon_s_addr", s_addr, m_addr[g*AW +: AW]);
                chk("mon_s_wr", s_wr, m_wr[g]);
                chk("mon_s_size", s_size, m_size[g*2 +: 2]);
                chk("mon_s_wstrb", s_wstrb, m_wstrb[g*SW +: SW]);
                chk("mon_s_wdata", s_wdata, m_wdata[g*DW +: DW]);
            end
            if (dopop) chk("mon_m_rdata", m_rdata, s_rdata);
            // advance to the state after the coming rising edge
            if (s_data_ok && q.size() == 0) mdl_proto = 1;
            if (dopop) void'(q.pop_front());
            if (e_sreq && s_addr_ok) begin
                q.push_back(g);
                pend = 0;
                rr   = (g + 1) % NUM_CH;
            end else if (e_sreq) begin
                pend    = 1;
                pend_id = g;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ch(input int ch, input logic req, input logic wr,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m_req[ch]             = req;
        m_wr[ch]              = wr;
        m_size[ch*2 +: 2]     = 2'd2;
        m_wstrb[ch*SW +: SW]  = wr ? {SW{1'b1}} : {SW{1'b0}};
        m_addr[ch*AW +: AW]   = addr;
        m_wdata[ch*DW +: DW]  = wdata;
    endtask

    task automatic idle();
        m_req     = '0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            s_data_ok = 1'b1;
            s_rdata   = 32'h1000_0000 + i;
            cyc();
        end
        s_data_ok = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        m_req = '0; m_wr = '0; m_size = '0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;

        // reset: outputs quiet even with requests present
        m_req = 2'b11;
        cyc();
        #2;
        chk("reset_s_req", s_req, 0);
        chk("reset_addr_ok", m_addr_ok, 0);
        chk("reset_outst", outst_cnt, 0);
        chk("reset_proto", proto_err, 0);
        cyc();
        idle();
        resetn = 1'b1;
        cyc();

        // 1: single read on ch0, response two cycles after accept
        drive_ch(0, 1, 0, 32'h100, 0);
        s_addr_ok = 1'b1;
        #2;
        chk("t1_addr_ok", m_addr_ok, 2'b01);
        chk("t1_s_addr", s_addr, 32'h100);
        chk("t1_outst0", outst_cnt, 0);
        cyc();
        idle();
        #2 chk("t1_outst1", outst_cnt, 1);
        cyc();
        s_data_ok = 1'b1;
        s_rdata   = 32'hDEADBEEF;
        #2;
        chk("t1_data_ok", m_data_ok, 2'b01);
        chk("t1_rdata", m_rdata, 32'hDEADBEEF);
        cyc();
        s_data_ok = 1'b0;
        #2 chk("t1_outst2", outst_cnt, 0);
        cyc();

        // 2: simultaneous requests
`ifdef RR_ARB_EN
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        cyc();
        drive_ch(0, 1, 0, 32'h200, 0);
        drive_ch(1, 1, 1, 32'h204, 32'hA5A5_0001);
        s_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2 chk("t2_rr_grant", m_addr_ok, (k % 2 == 1) ? 2'b10 : 2'b01);
            cyc();
        end
        idle();
        drain(4);
`else
        drive_ch(0, 1, 0, 32'h200, 0);
        drive_ch(1, 1, 1, 32'h204, 32'hA5A5_0001);
        s_addr_ok = 1'b1;
        #2;
        chk("t2_first", m_addr_ok, 2'b10);
        chk("t2_first_addr", s_addr, 32'h204);
        cyc();
        drive_ch(1, 0, 0, 0, 0);
        #2 chk("t2_second", m_addr_ok, 2'b01);
        cyc();
        idle();
        drain(2);
`endif
        cyc();

        // 3: stalled downstream keeps ch0's address while ch1 arrives
        drive_ch(0, 1, 0, 32'h300, 0);
        cyc();
        cyc();
        drive_ch(1, 1, 0, 32'h304, 0);
        #2;
        chk("t3_hold_addr", s_addr, 32'h300);
        chk("t3_no_accept", m_addr_ok, 2'b00);
        cyc();
        s_addr_ok = 1'b1;
        #2 chk("t3_ch0_first", m_addr_ok, 2'b01);
        cyc();
        drive_ch(0, 0, 0, 0, 0);
        #2 chk("t3_ch1_next", m_addr_ok, 2'b10);
        cyc();
        idle();
        drain(2);
        cyc();

        // 4: fill the ID FIFO, then free one slot
        drive_ch(0, 1, 1, 32'h400, 32'h0BAD_F00D);
        s_addr_ok = 1'b1;
        for (int k = 0; k < MAX_OUTST; k++) cyc();
        #2;
        chk("t4_full_cnt", outst_cnt, 4);
        chk("t4_full_sreq", s_req, 0);
        chk("t4_full_aok", m_addr_ok, 0);
        cyc();
        s_data_ok = 1'b1;
        #2;
        chk("t4_pop_sreq", s_req, 0);
        chk("t4_pop_dok", m_data_ok, 2'b01);
        cyc();
        s_data_ok = 1'b0;
        #2;
        chk("t4_after_cnt", outst_cnt, 3);
        chk("t4_after_sreq", s_req, 1);
        cyc();
        idle();
        drain(4);
        cyc();

        // 5: IDs 1,0,1 outstanding; responses in order, one with a concurrent push
        drive_ch(1, 1, 0, 32'h500, 0);
        s_addr_ok = 1'b1;
        cyc();
        drive_ch(1, 0, 0, 0, 0);
        drive_ch(0, 1, 0, 32'h504, 0);
        cyc();
        drive_ch(0, 0, 0, 0, 0);
        drive_ch(1, 1, 0, 32'h508, 0);
        cyc();
        drive_ch(1, 0, 0, 0, 0);
        drive_ch(0, 1, 0, 32'h50C, 0);
        s_data_ok = 1'b1;
        s_rdata   = 32'h5555_0001;
        #2;
        chk("t5_dok1", m_data_ok, 2'b10);
        chk("t5_push_aok", m_addr_ok, 2'b01);
        cyc();
        drive_ch(0, 0, 0, 0, 0);
        s_rdata = 32'h5555_0002;
        #2;
        chk("t5_dok2", m_data_ok, 2'b01);
        chk("t5_cnt_same", outst_cnt, 3);
        cyc();
        #2 chk("t5_dok3", m_data_ok, 2'b10);
        cyc();
        #2 chk("t5_dok4", m_data_ok, 2'b01);
        cyc();
        idle();
        #2 chk("t5_empty", outst_cnt, 0);
        cyc();

        // 6: stray response sets sticky error; async reset mid-traffic
        s_data_ok = 1'b1;
        #2 chk("t6_no_dok", m_data_ok, 0);
        cyc();
        s_data_ok = 1'b0;
        #2 chk("t6_proto", proto_err, 1);
        cyc();
        cyc();
        #2 chk("t6_proto_held", proto_err, 1);
        drive_ch(0, 1, 0, 32'h600, 0);
        s_addr_ok = 1'b1;
        cyc();
        drive_ch(0, 0, 0, 0, 0);
        drive_ch(1, 1, 0, 32'h604, 0);
        s_addr_ok = 1'b0;
        #2 chk("t6_pre_rst_cnt", outst_cnt, 1);
        cyc();
        resetn    = 1'b0;
        m_req     = 2'b11;
        s_addr_ok = 1'b1;
        #2;
        chk("t6_async_cnt", outst_cnt, 0);
        chk("t6_async_proto", proto_err, 0);
        chk("t6_async_sreq", s_req, 0);
        chk("t6_async_aok", m_addr_ok, 0);
        cyc();
        cyc();
        idle();
        resetn = 1'b1;
        cyc();
        s_data_ok = 1'b1;
        cyc();
        s_data_ok = 1'b0;
        #2 chk("t6_stray_proto", proto_err, 1);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
